// File: rtl/sap_pkg.sv
// Shared SAP datapath constants and the program/data memory control state type.
package sap_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PROG = 2'd1,
    DONE = 2'd2
  } ram_state_t;

endpackage

// File: rtl/sap_ram_if.sv
// Program-mode loader bundle: mode select, valid/ready word stream and load status.
interface sap_ram_if #(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W
);

  logic              prog_mode;
  logic [DATA_W-1:0] prog_data;
  logic              prog_valid;
  logic              prog_ready;
  logic              prog_done;
  logic [ADDR_W-1:0] load_ptr;

  modport master (
    output prog_mode, prog_data, prog_valid,
    input  prog_ready, prog_done, load_ptr
  );

  modport slave (
    input  prog_mode, prog_data, prog_valid,
    output prog_ready, prog_done, load_ptr
  );

endinterface

// File: rtl/sap_ram_loader.sv
// Control FSM of the SAP RAM: run/program/done states, auto-incrementing
// load pointer and the valid/ready handshake that produces the write strobe.
module sap_ram_loader
  import sap_pkg::*;
#(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DEPTH  = sap_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              clr,
  sap_ram_if.slave          prog,
  output ram_state_t        state,
  output logic              we,
  output logic [ADDR_W-1:0] waddr
);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              last;

  assign last = (ptr_q == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= RUN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we      = 1'b0;
    case (state_q)
      RUN: begin
        if (prog.prog_mode) begin
          state_d = PROG;
          ptr_d   = '0;
        end
      end
      PROG: begin
        // Leaving program mode wins over a word offered in the same cycle.
        if (!prog.prog_mode) begin
          state_d = RUN;
          ptr_d   = '0;
        end else if (prog.prog_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          if (last) state_d = DONE;
        end
      end
      DONE: begin
        if (!prog.prog_mode) begin
          state_d = RUN;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = RUN;
        ptr_d   = '0;
      end
    endcase
  end

  assign prog.prog_ready = (state_q == PROG) && prog.prog_mode;
  assign prog.prog_done  = (state_q == DONE);
  assign prog.load_ptr   = ptr_q;
  assign state           = state_q;
  assign waddr           = ptr_q;

endmodule

// File: rtl/sap_ram.sv
// 16x8 SAP program/data memory with registered bus read and program-mode loader.
// Build option: define RAM_CLEAR_EN to zero every word on a clr edge.
module sap_ram
  import sap_pkg::*;
#(
  parameter int ADDR_W = sap_pkg::ADDR_W,
  parameter int DATA_W = sap_pkg::DATA_W,
  parameter int DEPTH  = sap_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              ce_n,
  sap_ram_if.slave          prog,
  output wire  [DATA_W-1:0] bus_out
);

  ram_state_t        state;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;
  logic              rd_en;

  sap_ram_loader #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_loader (
    .clk   (clk),
    .clr   (clr),
    .prog  (prog),
    .state (state),
    .we    (we),
    .waddr (waddr)
  );

`ifdef RAM_CLEAR_EN
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= prog.prog_data;
    end
  end
`else
  // clr only aborts the session; stored words survive it.
  always_ff @(posedge clk) begin
    if (we && !clr) mem[waddr] <= prog.prog_data;
  end
`endif

  assign rd_en = (state == RUN) && !ce_n;

  always_ff @(posedge clk) begin
    if (clr) rd_q <= '0;
    else if (rd_en) rd_q <= mem[mar_addr];
  end

  assign bus_out = rd_en ? rd_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sap_ram.sv
// Directed + randomized bench for sap_ram against a behavioural memory/loader model.
module tb_sap_ram;
  import sap_pkg::*;

  localparam logic [DATA_W-1:0] HIZ = '1;  // pulled-up bus reads as all ones

  logic              clk = 1'b0;
  logic              clr;
  logic [ADDR_W-1:0] mar_addr;
  logic              ce_n;
  tri1  [DATA_W-1:0] bus_out;

  sap_ram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

  sap_ram dut (
    .clk      (clk),
    .clr      (clr),
    .mar_addr (mar_addr),
    .ce_n     (ce_n),
    .prog     (pif),
    .bus_out  (bus_out)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd;
  bit                m_prog, m_done;
  int                m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the pre-edge inputs, then compare all outputs.
  task automatic step();
    bit run;
    run = !m_prog && !m_done;
    if (clr) begin
`ifdef RAM_CLEAR_EN
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
`endif
      m_prog = 0; m_done = 0; m_ptr = 0; m_rd = '0;
    end else begin
      if (run && !ce_n) m_rd = m_mem[mar_addr];
      if (run && pif.prog_mode) begin
        m_prog = 1; m_ptr = 0;
      end else if ((m_prog || m_done) && !pif.prog_mode) begin
        m_prog = 0; m_done = 0; m_ptr = 0;
      end else if (m_prog && pif.prog_valid) begin
        m_mem[m_ptr] = pif.prog_data;
        if (m_ptr == DEPTH - 1) begin
          m_prog = 0; m_done = 1; m_ptr = 0;
        end else begin
          m_ptr = m_ptr + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    run = !m_prog && !m_done;
    chk("prog_ready", 32'(pif.prog_ready), 32'(m_prog && pif.prog_mode));
    chk("prog_done", 32'(pif.prog_done), 32'(m_done));
    chk("load_ptr", 32'(pif.load_ptr), 32'(m_ptr));
    chk("bus_out", 32'(bus_out), 32'((run && !ce_n) ? m_rd : HIZ));
  endtask

  task automatic read_at(input int a);
    mar_addr = ADDR_W'(a);
    ce_n = 1'b0;
    step();
  endtask

  initial begin
    clr = 1'b1; ce_n = 1'b1; mar_addr = '0;
    pif.prog_mode = 1'b0; pif.prog_valid = 1'b0; pif.prog_data = '0;
    m_prog = 0; m_done = 0; m_ptr = 0; m_rd = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

    // Reset with bus disabled, then with bus enabled (registered data reads 0).
    step();
    ce_n = 1'b0;
    step();
    chk("reset_bus_zero", 32'(bus_out), 32'h0);
    clr = 1'b0; ce_n = 1'b1;

    // Full back-to-back load of 0x10..0x1F.
    pif.prog_mode = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      pif.prog_valid = 1'b1;
      pif.prog_data  = DATA_W'(8'h10 + i);
      step();
    end
    chk("done_after_16", 32'(pif.prog_done), 32'h1);
    chk("ready_after_16", 32'(pif.prog_ready), 32'h0);
    // Valid held in DONE: no writes, pointer parked.
    pif.prog_data = 8'hEE;
    for (int i = 0; i < 5; i++) step();
    pif.prog_valid = 1'b0; pif.prog_mode = 1'b0;
    step();
    read_at(5);
    chk("read_addr5", 32'(bus_out), 32'h15);

    // Random reads with random enable.
    for (int i = 0; i < 24; i++) begin
      mar_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      ce_n = 1'($urandom_range(0, 1));
      step();
    end
    ce_n = 1'b1;

    // Two words, then prog_mode falls with a word still offered.
    pif.prog_mode = 1'b1;
    step();
    pif.prog_valid = 1'b1; pif.prog_data = 8'hAA; step();
    pif.prog_data = 8'hBB; step();
    pif.prog_data = 8'hCC; pif.prog_mode = 1'b0; step();
    pif.prog_valid = 1'b0;
    chk("abort_ptr", 32'(pif.load_ptr), 32'h0);
    read_at(0); read_at(1); read_at(2);
    read_at(2);
    chk("addr2_kept", 32'(bus_out), 32'h12);

    // Reads suppressed in PROG, then ce_n toggling in RUN.
    pif.prog_mode = 1'b1; mar_addr = '0; ce_n = 1'b0;
    step(); step();
    chk("prog_bus_hiz", 32'(bus_out), 32'(HIZ));
    pif.prog_mode = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      ce_n = ~ce_n;
      mar_addr = ADDR_W'(i);
      step();
    end
    ce_n = 1'b1;

    // Eight random words then clr mid-load, then read everything back.
    pif.prog_mode = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      pif.prog_valid = 1'b1;
      pif.prog_data = DATA_W'($urandom);
      step();
    end
    clr = 1'b1; step();
    clr = 1'b0; pif.prog_valid = 1'b0; pif.prog_mode = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      read_at(a);
      read_at(a);
    end

    // Random mixed traffic with occasional clr and mode flips.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 14) == 0) pif.prog_mode = ~pif.prog_mode;
      pif.prog_valid = 1'($urandom_range(0, 3) != 0);
      pif.prog_data  = DATA_W'($urandom);
      mar_addr       = ADDR_W'($urandom_range(0, DEPTH - 1));
      ce_n           = 1'($urandom_range(0, 1));
      clr            = ($urandom_range(0, 59) == 0);
      step();
    end
    clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
